// File: rtl/latch_ctr_pkg.sv
// latch_ctr_pkg: shared states, mode codes and next-value helper for the latch counter sequencer
package latch_ctr_pkg;
  localparam int MAX_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, SETUP, M_EN, GAP_A, S_EN, GAP_B, DONE} state_t;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  typedef struct packed {
    logic                 wrap;
    logic [MAX_WIDTH-1:0] val;
  } nxt_t;
  // Operands are zero-extended to MAX_WIDTH; width selects the live low bits.
  function automatic nxt_t next_value(input logic [1:0] mode, input logic [MAX_WIDTH-1:0] q,
                                      input logic [MAX_WIDTH-1:0] ld, input int width);
    logic [MAX_WIDTH-1:0] mask;
    nxt_t r;
    mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    r.val = mode == MODE_UP ? (q + 1'b1) & mask :
            mode == MODE_DOWN ? (q - 1'b1) & mask :
            mode == MODE_LOAD ? ld & mask : q & mask;
    r.wrap = (mode == MODE_UP && (q & mask) == mask) || (mode == MODE_DOWN && (q & mask) == '0);
    return r;
  endfunction
endpackage

// File: rtl/latch_ctr_sequencer_phase_timer.sv
// phase_timer: loadable down-counter, tc marks the last cycle of a loaded duration
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign tc = cnt == W'(1);
endmodule

// File: rtl/latch_ctr_sequencer.sv
// latch_ctr_sequencer: drives master/slave latch banks with non-overlapping enables to form a counter register
module latch_ctr_sequencer
  import latch_ctr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PULSE = 2,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] m_d,
  output logic             m_e,
  output logic             s_e,
  output logic             busy,
  output logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  localparam int TMAX = PULSE > GAP ? PULSE : GAP;
  localparam int TW = $clog2(TMAX + 1);
  if (PULSE < 1 || GAP < 1 || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_params
    $error("latch_ctr_sequencer: PULSE and GAP must be >= 1, WIDTH in 1..MAX_WIDTH");
  end
  state_t state, nstate;
  nxt_t nv;
  logic [WIDTH-1:0] nxt, nxt_r;
  logic wrap_r, accept, tc, t_load;
  logic [TW-1:0] dur;
  assign nv = next_value(mode, MAX_WIDTH'(q_in), MAX_WIDTH'(load_val), WIDTH);
  assign nxt = nv.val[WIDTH-1:0];
  if (WIDTH < MAX_WIDTH) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^nv.val[MAX_WIDTH-1:WIDTH];
  end
  assign accept = state == IDLE && req;
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = req ? (mode == MODE_HOLD ? DONE : SETUP) : IDLE;
      SETUP:   nstate = M_EN;
      M_EN:    nstate = tc ? GAP_A : M_EN;
      GAP_A:   nstate = tc ? S_EN : GAP_A;
      S_EN:    nstate = tc ? GAP_B : S_EN;
      GAP_B:   nstate = tc ? DONE : GAP_B;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  // Timer reloads on entry to every timed phase so its terminal count ends that phase.
  assign t_load = nstate != state && nstate inside {M_EN, GAP_A, S_EN, GAP_B};
  assign dur = (nstate == M_EN || nstate == S_EN) ? TW'(PULSE) : TW'(GAP);
  phase_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(t_load),
    .load_val(dur),
    .tc(tc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      m_d    <= '0;
      m_e    <= 1'b0;
      s_e    <= 1'b0;
      busy   <= 1'b0;
      ack    <= 1'b0;
      count  <= '0;
      wrap   <= 1'b0;
      nxt_r  <= '0;
      wrap_r <= 1'b0;
    end else begin
      state <= nstate;
      m_e   <= nstate == M_EN;
      s_e   <= nstate == S_EN;
      busy  <= nstate != IDLE;
      ack   <= nstate == DONE;
      wrap  <= nstate == DONE && (accept ? nv.wrap : wrap_r);
      if (accept) begin
        nxt_r  <= nxt;
        wrap_r <= nv.wrap;
      end
      if (accept && mode != MODE_HOLD) m_d <= nxt;
      if (nstate == DONE) count <= accept ? nxt : nxt_r;
    end
  end
endmodule

// File: tb/tb_latch_ctr_sequencer.sv
// tb_latch_ctr_sequencer: randomized scoreboard bench with a behavioural latch-pair and counter model
module tb_latch_ctr_sequencer;
  import latch_ctr_pkg::*;
  localparam int W = 4, P = 2, G = 1;
  localparam int LAT = 1 + 2 * P + 2 * G;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] load_val = '0, q_in, m_d, count;
  logic m_e, s_e, busy, ack, wrap;
  logic [W-1:0] mq = '0, sq = '0;
  assign q_in = sq;

  latch_ctr_sequencer #(.WIDTH(W), .PULSE(P), .GAP(G)) dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .load_val(load_val), .q_in(q_in),
    .m_d(m_d), .m_e(m_e), .s_e(s_e), .busy(busy), .ack(ack), .count(count), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0, cyc = 0;
  typedef struct {
    logic [W-1:0] val;
    logic         wr;
    int           at;
    logic         hold;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Counter arithmetic on plain integers; ack edge counted from the accepting edge.
  function automatic exp_t model(input logic [1:0] m, input int q, input int ld, input int acc);
    exp_t r;
    int v, md;
    md = 1 << W;
    v = m == MODE_UP ? q + 1 : m == MODE_DOWN ? q - 1 : m == MODE_LOAD ? ld : q;
    r.wr = v < 0 || v >= md;
    r.val = W'((v + md) % md);
    r.hold = m == MODE_HOLD;
    r.at = acc + (m == MODE_HOLD ? 0 : LAT);
    return r;
  endfunction

  always @(posedge clk) cyc++;

  logic pm_e = 1'b0, ps_e = 1'b0;
  logic [W-1:0] pmd = '0;
  int me_run = 0, se_run = 0, since_me = 0;
  always @(negedge clk) begin
    if (m_e) mq = m_d;
    if (s_e) sq = mq;
    if (rst) begin
      sb.delete();
      me_run = 0;
      se_run = 0;
    end else begin
      if (!busy && req) sb.push_back(model(mode, int'(sq), int'(load_val), cyc + 1));
      chk("enable overlap", int'(m_e & s_e), 0);
      if (m_e || s_e) chk("m_d stable under enable", m_d, pmd);
      if (s_e && !ps_e) chk("non-overlap gap", since_me, G);
      if (!m_e && me_run != 0) chk("m_e pulse width", me_run, P);
      if (!s_e && se_run != 0) chk("s_e pulse width", se_run, P);
      if (busy && sb.size() != 0 && sb[0].hold) chk("hold enables", int'(m_e | s_e), 0);
      if (ack) begin
        if (sb.size() == 0) chk("unexpected ack", 1, 0);
        else begin
          e = sb.pop_front();
          chk("count", count, e.val);
          chk("wrap", wrap, e.wr);
          chk("ack latency", cyc, e.at);
          if (!e.hold) chk("m_d at ack", m_d, e.val);
        end
      end
      me_run = m_e ? me_run + 1 : 0;
      se_run = s_e ? se_run + 1 : 0;
    end
    since_me = m_e ? 0 : since_me + 1;
    pmd = m_d;
    pm_e = m_e;
    ps_e = s_e;
  end

  // Entered and left at posedge+1 with the DUT idle.
  task automatic txn(input logic [1:0] m, input logic [W-1:0] ld, input bit keep = 0,
                     input bit poke = 0, input logic [W-1:0] pk = '0);
    int n = 0;
    mode = m;
    load_val = ld;
    req = 1'b1;
    @(posedge clk);
    #1;
    if (poke) begin
      load_val = pk;
      mode = 2'($urandom_range(0, 3));
    end
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 40);
    if (!ack) chk("ack timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset m_d", m_d, 0);
    chk("reset m_e", m_e, 0);
    chk("reset s_e", s_e, 0);
    chk("reset busy", busy, 0);
    chk("reset ack", ack, 0);
    chk("reset count", count, 0);
    chk("reset wrap", wrap, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    sq = 4'h3;
    txn(MODE_UP, 4'h0);
    chk("up from 3 count", count, 4'h4);
    chk("up from 3 m_d", m_d, 4'h4);
    sq = 4'hF;
    txn(MODE_UP, 4'h0);
    chk("up wrap count", count, 4'h0);
    sq = 4'h0;
    txn(MODE_DOWN, 4'h0);
    chk("down wrap count", count, 4'hF);
    txn(MODE_LOAD, 4'hA, 0, 1, 4'h5);
    chk("load ignores busy change", count, 4'hA);
    chk("load m_d", m_d, 4'hA);
    sq = 4'h6;
    txn(MODE_HOLD, 4'h0);
    chk("hold count", count, 4'h6);

    sq = 4'h0;
    mode = MODE_UP;
    req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_e && n < 40);
    if (!s_e) chk("s_e timeout", 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst mid s_e", s_e, 0);
    chk("rst mid busy", busy, 0);
    chk("rst mid count", count, 0);
    chk("rst mid ack", ack, 0);
    @(posedge clk);
    #1 sq = 4'h0;
    txn(MODE_UP, 4'h0);
    chk("after rst count", count, 4'h1);

    sq = 4'h0;
    for (int i = 1; i <= 3; i++) begin
      txn(MODE_UP, 4'h0, i < 3);
      chk("back-to-back count", count, i);
    end

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) sq = W'($urandom);
      txn(2'($urandom_range(0, 3)), W'($urandom), i < 39 && $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1, W'($urandom));
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
